// File: rtl/fdtd_pkg.sv
// Shared types for the FDTD write-back engine.
// States, job kinds and bus byte-enable patterns.
package fdtd_pkg;

  typedef enum logic [2:0] {
    WB_IDLE,
    WB_RD_LO,
    WB_RD_HI,
    WB_CAP,
    WB_REQ,
    WB_RSP,
    WB_DONE
  } wb_state_e;

  typedef enum logic [1:0] {
    WB_HY,
    WB_EZ,
    WB_SRC
  } wb_kind_e;

  localparam logic [3:0] BUS_BE_FULL = 4'b1111;
  localparam logic [3:0] BUS_BE_LO   = 4'b0011;

endpackage

// File: rtl/fdtd_wb_arb.sv
// Start-edge capture and pending-job arbitration.
// Hy wins over Ez, Ez over src; a launch clears the chosen bit.
module fdtd_wb_arb
  import fdtd_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     hy_start_i,
  input  logic     ez_start_i,
  input  logic     src_start_i,
  input  logic     launch_i,
  output logic     kind_valid_o,
  output wb_kind_e kind_o
);

  logic [2:0] prev_q, prev_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] starts;
  logic [2:0] edges;
  logic [2:0] clr;

  assign starts = {src_start_i, ez_start_i, hy_start_i};
  assign edges  = starts & ~prev_q;

  always_comb begin
    kind_o = WB_HY;
    clr    = 3'b000;
    priority case (1'b1)
      pend_q[0]: begin
        kind_o = WB_HY;
        clr    = 3'b001;
      end
      pend_q[1]: begin
        kind_o = WB_EZ;
        clr    = 3'b010;
      end
      pend_q[2]: begin
        kind_o = WB_SRC;
        clr    = 3'b100;
      end
      default: begin
        kind_o = WB_HY;
        clr    = 3'b000;
      end
    endcase
    if (!launch_i) begin
      clr = 3'b000;
    end
    // A fresh edge in the launch cycle stays pending.
    pend_d = (pend_q & ~clr) | edges;
    prev_d = starts;
  end

  assign kind_valid_o = |pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 3'b000;
      pend_q <= 3'b000;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/fdtd_wb_ctrl.sv
// FDTD write-back engine: reads a Hy/Ez ping buffer and
// writes it to data memory two 16-bit samples per word.
module fdtd_wb_ctrl
  import fdtd_pkg::*;
#(
  parameter int BUFFER_ADDR_WIDTH = 6,
  parameter int FDTD_DATA_WIDTH   = 16,
  parameter int BUFFER_SIZE       = 50
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [15:0]                  buffer_size_i,
  input  logic [31:0]                  hy_base_addr_i,
  input  logic [31:0]                  ez_base_addr_i,
  input  logic                         wrt_Hy_start_i,
  input  logic                         wrt_Ez_start_i,
  input  logic                         wrt_src_start_i,
  output logic                         rd_Hy_buf_en_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] rd_Hy_buf_addr_o,
  input  logic [FDTD_DATA_WIDTH-1:0]   rd_Hy_buf_data_i,
  output logic                         rd_Ez_buf_en_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] rd_Ez_buf_addr_o,
  input  logic [FDTD_DATA_WIDTH-1:0]   rd_Ez_buf_data_i,
  output logic                         data_req_o,
  input  logic                         data_gnt_i,
  input  logic                         data_rvalid_i,
  output logic [31:0]                  data_addr_o,
  output logic                         data_we_o,
  output logic [3:0]                   data_be_o,
  output logic [31:0]                  data_wdata_o,
  output logic                         busy_o,
  output logic                         wb_done_o
);

  localparam int IW = BUFFER_ADDR_WIDTH + 1;
  localparam int AW = BUFFER_ADDR_WIDTH;
  localparam int DW = FDTD_DATA_WIDTH;
  localparam logic [15:0]   BSZ16 = 16'(BUFFER_SIZE);
  localparam logic [IW-1:0] BSZ_I = IW'(BUFFER_SIZE);

  wb_state_e state_q, state_d;
  wb_kind_e  arb_kind;
  logic      arb_valid;
  logic      launch;

  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] n_q, n_d;
  logic [IW-1:0] idx_nx;
  logic [IW-1:0] n_clamp;
  logic [31:0]   base_q, base_d;
  logic          sel_ez_q, sel_ez_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] rd_data;
  logic          has_hi;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          req;
  logic          done;
  logic [31:0]   word_addr;

  fdtd_wb_arb u_arb (
    .clk          (CLK),
    .rst          (RST),
    .hy_start_i   (wrt_Hy_start_i),
    .ez_start_i   (wrt_Ez_start_i),
    .src_start_i  (wrt_src_start_i),
    .launch_i     (launch),
    .kind_valid_o (arb_valid),
    .kind_o       (arb_kind)
  );

  assign n_clamp = (buffer_size_i > BSZ16) ? BSZ_I
                                           : buffer_size_i[IW-1:0];
  assign idx_nx  = idx_q + IW'(1);
  assign has_hi  = idx_nx < n_q;
  assign rd_data = sel_ez_q ? rd_Ez_buf_data_i : rd_Hy_buf_data_i;

  // Each sample is 2 bytes, so the word sits at base + 2*idx.
  assign word_addr = base_q + {{(31-IW){1'b0}}, idx_q, 1'b0};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    n_d      = n_q;
    base_d   = base_q;
    sel_ez_d = sel_ez_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    launch   = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    req      = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (arb_valid) begin
          launch   = 1'b1;
          idx_d    = '0;
          sel_ez_d = (arb_kind != WB_HY);
          unique case (1'b1)
            (arb_kind == WB_HY): begin
              n_d    = n_clamp;
              base_d = hy_base_addr_i;
            end
            (arb_kind == WB_EZ): begin
              n_d    = n_clamp;
              base_d = ez_base_addr_i;
            end
            default: begin
              n_d    = IW'(1);
              base_d = ez_base_addr_i;
            end
          endcase
          state_d = (n_d == '0) ? WB_DONE : WB_RD_LO;
        end
      end
      WB_RD_LO: begin
        rd_en   = 1'b1;
        rd_addr = idx_q[AW-1:0];
        state_d = WB_RD_HI;
      end
      WB_RD_HI: begin
        lo_d = rd_data;
        if (has_hi) begin
          rd_en   = 1'b1;
          rd_addr = idx_nx[AW-1:0];
        end
        state_d = WB_CAP;
      end
      WB_CAP: begin
        hi_d    = has_hi ? rd_data : '0;
        state_d = WB_REQ;
      end
      WB_REQ: begin
        req = 1'b1;
        if (data_gnt_i) begin
          state_d = WB_RSP;
        end
      end
      WB_RSP: begin
        if (data_rvalid_i) begin
          idx_d   = idx_q + IW'(2);
          state_d = (idx_d >= n_q) ? WB_DONE : WB_RD_LO;
        end
      end
      WB_DONE: begin
        done    = 1'b1;
        state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  assign rd_Hy_buf_en_o   = rd_en & ~sel_ez_q;
  assign rd_Ez_buf_en_o   = rd_en & sel_ez_q;
  assign rd_Hy_buf_addr_o = sel_ez_q ? '0 : rd_addr;
  assign rd_Ez_buf_addr_o = sel_ez_q ? rd_addr : '0;

  assign data_req_o   = req;
  assign data_we_o    = req;
  assign data_addr_o  = req ? word_addr : '0;
  assign data_wdata_o = req ? {hi_q, lo_q} : '0;
  assign data_be_o    = !req  ? 4'b0000
                      : has_hi ? BUS_BE_FULL : BUS_BE_LO;

  assign busy_o    = (state_q != WB_IDLE);
  assign wb_done_o = done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= WB_IDLE;
      idx_q    <= '0;
      n_q      <= '0;
      base_q   <= '0;
      sel_ez_q <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      base_q   <= base_d;
      sel_ez_q <= sel_ez_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

endmodule

// File: tb/tb_fdtd_wb_ctrl.sv
// Directed bench for fdtd_wb_ctrl: buffer RAM models,
// a delayed-grant bus responder and a write log.
module tb_fdtd_wb_ctrl;

  logic        CLK;
  logic        RST;
  logic [15:0] buffer_size_i;
  logic [31:0] hy_base_addr_i;
  logic [31:0] ez_base_addr_i;
  logic        wrt_Hy_start_i;
  logic        wrt_Ez_start_i;
  logic        wrt_src_start_i;
  logic        rd_Hy_buf_en_o;
  logic [5:0]  rd_Hy_buf_addr_o;
  logic [15:0] rd_Hy_buf_data_i;
  logic        rd_Ez_buf_en_o;
  logic [5:0]  rd_Ez_buf_addr_o;
  logic [15:0] rd_Ez_buf_data_i;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        busy_o;
  logic        wb_done_o;

  fdtd_wb_ctrl dut (
    .CLK              (CLK),
    .RST              (RST),
    .buffer_size_i    (buffer_size_i),
    .hy_base_addr_i   (hy_base_addr_i),
    .ez_base_addr_i   (ez_base_addr_i),
    .wrt_Hy_start_i   (wrt_Hy_start_i),
    .wrt_Ez_start_i   (wrt_Ez_start_i),
    .wrt_src_start_i  (wrt_src_start_i),
    .rd_Hy_buf_en_o   (rd_Hy_buf_en_o),
    .rd_Hy_buf_addr_o (rd_Hy_buf_addr_o),
    .rd_Hy_buf_data_i (rd_Hy_buf_data_i),
    .rd_Ez_buf_en_o   (rd_Ez_buf_en_o),
    .rd_Ez_buf_addr_o (rd_Ez_buf_addr_o),
    .rd_Ez_buf_data_i (rd_Ez_buf_data_i),
    .data_req_o       (data_req_o),
    .data_gnt_i       (data_gnt_i),
    .data_rvalid_i    (data_rvalid_i),
    .data_addr_o      (data_addr_o),
    .data_we_o        (data_we_o),
    .data_be_o        (data_be_o),
    .data_wdata_o     (data_wdata_o),
    .busy_o           (busy_o),
    .wb_done_o        (wb_done_o)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] hy_mem [0:63];
  logic [15:0] ez_mem [0:63];

  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic [3:0]  log_be   [$];

  int gnt_delay = 0;
  int waitc     = 0;
  int rv_cnt    = 0;
  int done_cnt  = 0;
  bit holding   = 0;
  logic [31:0] h_addr, h_data;
  logic [3:0]  h_be;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) begin
    if (rd_Hy_buf_en_o) rd_Hy_buf_data_i <= hy_mem[rd_Hy_buf_addr_o];
    if (rd_Ez_buf_en_o) rd_Ez_buf_data_i <= ez_mem[rd_Ez_buf_addr_o];
  end

  always @(negedge CLK) begin
    if (wb_done_o) done_cnt++;
  end

  // Grant after gnt_delay waiting cycles; rvalid the cycle after grant.
  always @(negedge CLK) begin
    data_rvalid_i = 1'b0;
    if (data_gnt_i) begin
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b1;
      rv_cnt++;
      check("req_before_rvalid", {31'b0, data_req_o}, 32'd0);
    end else if (data_req_o) begin
      check("bus_we", {31'b0, data_we_o}, 32'd1);
      if (!holding) begin
        holding = 1'b1;
        waitc   = 0;
        h_addr  = data_addr_o;
        h_data  = data_wdata_o;
        h_be    = data_be_o;
      end else begin
        check("hold_addr", data_addr_o, h_addr);
        check("hold_wdata", data_wdata_o, h_data);
        check("hold_be", {28'b0, data_be_o}, {28'b0, h_be});
      end
      if (waitc >= gnt_delay) begin
        data_gnt_i = 1'b1;
        holding    = 1'b0;
        log_addr.push_back(data_addr_o);
        log_data.push_back(data_wdata_o);
        log_be.push_back(data_be_o);
      end else begin
        waitc++;
      end
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_be.delete();
  endtask

  task automatic check_wr(input int i, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          input string tag);
    logic [31:0] oa, od;
    logic [3:0]  ob;
    oa = '1;
    od = '1;
    ob = '1;
    if (i < log_addr.size()) begin
      oa = log_addr[i];
      od = log_data[i];
      ob = log_be[i];
    end
    check({tag, "_addr"}, oa, a);
    check({tag, "_data"}, od, d);
    check({tag, "_be"}, {28'b0, ob}, {28'b0, be});
  endtask

  task automatic pulse(input logic [2:0] s);
    @(negedge CLK);
    wrt_Hy_start_i  = s[0];
    wrt_Ez_start_i  = s[1];
    wrt_src_start_i = s[2];
    @(negedge CLK);
    wrt_Hy_start_i  = 1'b0;
    wrt_Ez_start_i  = 1'b0;
    wrt_src_start_i = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge CLK);
      if (wb_done_o) seen = 1'b1;
    end
    check(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
    check({tag, "_req"}, {31'b0, data_req_o}, 32'd0);
    check({tag, "_done"}, {31'b0, wb_done_o}, 32'd0);
    check({tag, "_rden"}, {30'b0, rd_Hy_buf_en_o, rd_Ez_buf_en_o}, 32'd0);
    check({tag, "_addr"}, data_addr_o, 32'd0);
    check({tag, "_wdata"}, data_wdata_o, 32'd0);
    check({tag, "_be"}, {28'b0, data_be_o}, 32'd0);
  endtask

  int d0, r0, nw, wt;

  initial begin
    RST              = 1'b1;
    wrt_Hy_start_i   = 1'b0;
    wrt_Ez_start_i   = 1'b0;
    wrt_src_start_i  = 1'b0;
    data_gnt_i       = 1'b0;
    data_rvalid_i    = 1'b0;
    buffer_size_i    = 16'd0;
    hy_base_addr_i   = 32'h1000;
    ez_base_addr_i   = 32'h2000;
    rd_Hy_buf_data_i = 16'h0;
    rd_Ez_buf_data_i = 16'h0;
    for (int i = 0; i < 64; i++) begin
      hy_mem[i] = 16'hA000 + 16'(i);
      ez_mem[i] = 16'hE000 + 16'(i);
    end
    ez_mem[0] = 16'h1234;

    repeat (3) @(negedge CLK);
    check_quiet("rst");
    RST = 1'b0;

    // Hy, N=4, immediate bus
    buffer_size_i = 16'd4;
    clear_log();
    d0 = done_cnt;
    r0 = rv_cnt;
    pulse(3'b001);
    wait_done(100, "t1_done");
    check("t1_rv_at_done", 32'(rv_cnt - r0), 32'd2);
    repeat (3) @(negedge CLK);
    check("t1_nwr", 32'(log_addr.size()), 32'd2);
    check_wr(0, 32'h1000, 32'hA001A000, 4'hF, "t1_w0");
    check_wr(1, 32'h1004, 32'hA003A002, 4'hF, "t1_w1");
    check("t1_ndone", 32'(done_cnt - d0), 32'd1);
    check("t1_idle", {31'b0, busy_o}, 32'd0);

    // Ez, N=5, odd tail
    buffer_size_i = 16'd5;
    clear_log();
    d0 = done_cnt;
    pulse(3'b010);
    wait_done(100, "t2_done");
    repeat (3) @(negedge CLK);
    check("t2_nwr", 32'(log_addr.size()), 32'd3);
    check_wr(0, 32'h2000, 32'hE0011234, 4'hF, "t2_w0");
    check_wr(1, 32'h2004, 32'hE003E002, 4'hF, "t2_w1");
    check_wr(2, 32'h2008, 32'h0000E004, 4'h3, "t2_w2");
    check("t2_ndone", 32'(done_cnt - d0), 32'd1);

    // Hy and Ez edges together, N=2
    buffer_size_i = 16'd2;
    clear_log();
    d0 = done_cnt;
    pulse(3'b011);
    wait_done(100, "t3_done_a");
    check("t3_nwr_a", 32'(log_addr.size()), 32'd1);
    wait_done(100, "t3_done_b");
    repeat (3) @(negedge CLK);
    check("t3_nwr", 32'(log_addr.size()), 32'd2);
    check_wr(0, 32'h1000, 32'hA001A000, 4'hF, "t3_w0");
    check_wr(1, 32'h2000, 32'hE0011234, 4'hF, "t3_w1");
    check("t3_ndone", 32'(done_cnt - d0), 32'd2);

    // Delayed grant, Hy N=4
    gnt_delay     = 3;
    buffer_size_i = 16'd4;
    clear_log();
    pulse(3'b001);
    wait_done(200, "t4_done");
    repeat (3) @(negedge CLK);
    check("t4_nwr", 32'(log_addr.size()), 32'd2);
    check_wr(0, 32'h1000, 32'hA001A000, 4'hF, "t4_w0");
    check_wr(1, 32'h1004, 32'hA003A002, 4'hF, "t4_w1");
    gnt_delay = 0;

    // Source job ignores buffer_size_i
    buffer_size_i = 16'd50;
    clear_log();
    d0 = done_cnt;
    pulse(3'b100);
    wait_done(100, "t5_done");
    repeat (3) @(negedge CLK);
    check("t5_nwr", 32'(log_addr.size()), 32'd1);
    check_wr(0, 32'h2000, 32'h00001234, 4'h3, "t5_w0");
    check("t5_ndone", 32'(done_cnt - d0), 32'd1);

    // Reset mid-job in RSP with an Ez job pending
    buffer_size_i = 16'd50;
    clear_log();
    pulse(3'b001);
    pulse(3'b010);
    wt = 0;
    while (log_addr.size() < 3 && wt < 200) begin
      @(negedge CLK);
      wt++;
    end
    check("t6_reach_w2", {31'b0, (log_addr.size() >= 3)}, 32'd1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    check_quiet("t6_rst");
    @(negedge CLK);
    RST = 1'b0;
    nw = log_addr.size();
    d0 = done_cnt;
    repeat (20) @(negedge CLK);
    check("t6_no_job", {31'b0, busy_o}, 32'd0);
    check("t6_no_wr", 32'(log_addr.size()), 32'(nw));
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);

    buffer_size_i = 16'd3;
    clear_log();
    pulse(3'b001);
    wait_done(100, "t6_done");
    repeat (3) @(negedge CLK);
    check("t6_nwr", 32'(log_addr.size()), 32'd2);
    check_wr(0, 32'h1000, 32'hA001A000, 4'hF, "t6_w0");
    check_wr(1, 32'h1004, 32'h0000A002, 4'h3, "t6_w1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
